// File: rtl/ball_split_ctrl.sv
// ball_split_ctrl: hit resolver that kills the shot ball once per frame and spawns its two children.
// Ports:
//   clk_i, reset_i (async, active high)
//   start_of_frame_i, game_start_i : one-cycle pulses
//   pixel_x_i, pixel_y_i            : current pixel position
//   shot_request_i, ball_requests_i : shot and per-slot draw requests (heap-ordered slots 0..14)
//   ball_alive_o                    : per-slot alive enables
//   spawn_pulse_o, spawn_x_o/y_o    : one-hot spawn strobe with spawn position
//   hit_pulse_o, hit_size_o         : hit strobe and size of the killed ball (0 huge .. 3 small)
//   level_cleared_o                 : strobe when the last ball dies
module ball_split_ctrl #(
    parameter logic [10:0] START_X      = 11'd320,
    parameter logic [10:0] START_Y      = 11'd100,
    parameter logic [10:0] SPAWN_OFFSET = 11'd16,
    parameter logic [10:0] X_MAX        = 11'd639
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_of_frame_i,
    input  logic        game_start_i,
    input  logic [10:0] pixel_x_i,
    input  logic [10:0] pixel_y_i,
    input  logic        shot_request_i,
    input  logic [14:0] ball_requests_i,
    output logic [14:0] ball_alive_o,
    output logic [14:0] spawn_pulse_o,
    output logic [10:0] spawn_x_o,
    output logic [10:0] spawn_y_o,
    output logic        hit_pulse_o,
    output logic [1:0]  hit_size_o,
    output logic        level_cleared_o
);
    typedef enum logic [2:0] {IDLE, PLAY, KILL, SPAWN_L, SPAWN_R} state_t;
    state_t        state_q;
    logic [14:0]   alive_q, pulse_q, cand;
    logic [10:0]   sx_q, sy_q, hx_q, hy_q, lx, rxc;
    logic          hit_q, clr_q, full_q;
    logic [1:0]    size_q, lvl;
    logic [3:0]    h_q, win, lc, rc;
    logic [11:0]   rx;
    logic signed [11:0] ls;

    assign cand = {15{shot_request_i}} & ball_requests_i & alive_q;

    // Deeper levels are scanned last so they override; descending index keeps the lowest slot of a level.
    always_comb begin
        win = 4'd0;
        for (int i = 2; i >= 1; i--) if (cand[i]) win = 4'(i);
        for (int i = 6; i >= 3; i--) if (cand[i]) win = 4'(i);
        for (int i = 14; i >= 7; i--) if (cand[i]) win = 4'(i);
    end

    assign lvl = (h_q == 4'd0) ? 2'd0 : (h_q <= 4'd2) ? 2'd1 : (h_q <= 4'd6) ? 2'd2 : 2'd3;
    assign lc  = {h_q[2:0], 1'b1};
    assign rc  = lc + 4'd1;
    assign ls  = $signed({1'b0, hx_q}) - $signed({1'b0, SPAWN_OFFSET});
    assign lx  = ls[11] ? 11'd0 : ls[10:0];
    assign rx  = {1'b0, hx_q} + {1'b0, SPAWN_OFFSET};
    assign rxc = (rx > {1'b0, X_MAX}) ? X_MAX : rx[10:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            alive_q <= '0;
            pulse_q <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            hit_q   <= 1'b0;
            size_q  <= '0;
            clr_q   <= 1'b0;
            full_q  <= 1'b0;
            h_q     <= '0;
            hx_q    <= '0;
            hy_q    <= '0;
        end else begin
            pulse_q <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            hit_q   <= 1'b0;
            size_q  <= '0;
            clr_q   <= 1'b0;
            case (state_q)
                IDLE: if (game_start_i) begin
                    alive_q <= 15'h0001;
                    pulse_q <= 15'h0001;
                    sx_q    <= START_X;
                    sy_q    <= START_Y;
                    state_q <= PLAY;
                end
                PLAY: begin
                    if (!full_q && cand != '0) begin
                        full_q <= 1'b1;
                        h_q    <= win;
                        hx_q   <= pixel_x_i;
                        hy_q   <= pixel_y_i;
                    end
                    if (start_of_frame_i && full_q) begin
                        alive_q[h_q] <= 1'b0;
                        hit_q        <= 1'b1;
                        size_q       <= lvl;
                        state_q      <= KILL;
                    end else if (alive_q == '0 && !full_q) begin
                        clr_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                KILL: if (lvl == 2'd3) begin
                    full_q  <= 1'b0;
                    state_q <= PLAY;
                end else begin
                    alive_q[lc] <= 1'b1;
                    pulse_q[lc] <= 1'b1;
                    sx_q        <= lx;
                    sy_q        <= hy_q;
                    state_q     <= SPAWN_L;
                end
                SPAWN_L: begin
                    alive_q[rc] <= 1'b1;
                    pulse_q[rc] <= 1'b1;
                    sx_q        <= rxc;
                    sy_q        <= hy_q;
                    state_q     <= SPAWN_R;
                end
                SPAWN_R: begin
                    full_q  <= 1'b0;
                    state_q <= PLAY;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ball_alive_o    = alive_q;
    assign spawn_pulse_o   = pulse_q;
    assign spawn_x_o       = sx_q;
    assign spawn_y_o       = sy_q;
    assign hit_pulse_o     = hit_q;
    assign hit_size_o      = size_q;
    assign level_cleared_o = clr_q;
endmodule
